// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to the TX and RX paths,
// and the parity-type constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b111,
    STOP   = 3'b101
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator shared by the UART TX and RX paths:
// yields the bit that makes data+parity even (type EVEN) or odd (type ODD).
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_type,
  output logic                  o_bit
);

  assign o_bit = (^i_data) ^ (i_type == PARITY_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a byte on DataValid while idle and serialises
// start, data LSB-first, optional parity and stop, each held BAUD_DIV clocks.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] PData,
  input  logic                  DataValid,
  input  logic                  ParityEn,
  input  logic                  ParityType,
  output logic                  TxOut,
  output logic                  Busy
);

  localparam int EDGE_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           r_state, w_state_next;
  logic [EDGE_W-1:0]     r_edge, w_edge_next;
  logic [BIT_W-1:0]      r_bit, w_bit_next;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg_next;
  logic                  r_par_en, w_par_en_next;
  logic                  r_par_bit, w_par_bit_next;
  logic                  r_tx, w_tx_next;
  logic                  r_busy, w_busy_next;
  logic                  w_bit_end;
  logic                  w_par_calc;

  // Parity is taken from the incoming byte at accept time, so the shifting
  // register never needs an untouched copy of the payload.
  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data(PData),
    .i_type(ParityType),
    .o_bit (w_par_calc)
  );

  assign w_bit_end = (r_edge == EDGE_W'(BAUD_DIV - 1));

  always_comb begin
    w_state_next   = r_state;
    w_edge_next    = r_edge + EDGE_W'(1);
    w_bit_next     = r_bit;
    w_shreg_next   = r_shreg;
    w_par_en_next  = r_par_en;
    w_par_bit_next = r_par_bit;

    case (r_state)
      IDLE: begin
        w_edge_next = '0;
        if (DataValid) begin
          w_state_next   = START;
          w_shreg_next   = PData;
          w_par_en_next  = ParityEn;
          w_par_bit_next = w_par_calc;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_edge_next  = '0;
          w_bit_next   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_edge_next = '0;
          if (r_bit != BIT_W'(DATA_WIDTH - 1)) begin
            w_shreg_next = r_shreg >> 1;
            w_bit_next   = r_bit + BIT_W'(1);
          end else begin
            w_state_next = r_par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
          w_edge_next  = '0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
          w_edge_next  = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_edge_next  = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered line
    // already shows the start bit in the cycle right after accept.
    w_tx_next   = 1'b1;
    w_busy_next = 1'b1;
    case (w_state_next)
      IDLE:    w_busy_next = 1'b0;
      START:   w_tx_next   = 1'b0;
      DATA:    w_tx_next   = w_shreg_next[0];
      PARITY:  w_tx_next   = w_par_bit_next;
      STOP:    w_tx_next   = 1'b1;
      default: w_busy_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_edge    <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_edge    <= w_edge_next;
      r_bit     <= w_bit_next;
      r_shreg   <= w_shreg_next;
      r_par_en  <= w_par_en_next;
      r_par_bit <= w_par_bit_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
    end
  end

  assign TxOut = r_tx;
  assign Busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus random frames
// compared cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx_frame;

  localparam int DW = 8;
  localparam int BD = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] PData = '0;
  logic          DataValid = 1'b0;
  logic          ParityEn = 1'b0;
  logic          ParityType = 1'b0;
  logic          TxOut;
  logic          Busy;

  int n_tests = 0;
  int n_fail  = 0;

  bit exp_bits [0:15];
  int exp_n;

  uart_tx_frame #(
    .DATA_WIDTH(DW),
    .BAUD_DIV  (BD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PData     (PData),
    .DataValid (DataValid),
    .ParityEn  (ParityEn),
    .ParityType(ParityType),
    .TxOut     (TxOut),
    .Busy      (Busy)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame as a list of line levels: start, data LSB-first, parity, stop.
  task automatic build_frame(input logic [DW-1:0] d, input bit pen, input bit pt);
    exp_n = 0;
    exp_bits[exp_n++] = 1'b0;
    for (int i = 0; i < DW; i++) exp_bits[exp_n++] = d[i];
    if (pen) exp_bits[exp_n++] = bit'(($countones(d) + int'(pt)) % 2);
    exp_bits[exp_n++] = 1'b1;
  endtask

  // Called at the falling edge right after the accepting rising edge.
  task automatic check_frame(input logic [DW-1:0] d, input bit pen, input bit pt,
                             input bit scramble);
    logic [DW-1:0] rx_byte;
    int            busy_cycles;
    rx_byte = '0;
    busy_cycles = 0;
    build_frame(d, pen, pt);
    for (int k = 0; k < exp_n * BD; k++) begin
      check_val("tx_bit", 32'(TxOut), 32'(exp_bits[k / BD]));
      check_val("busy", 32'(Busy), 32'd1);
      if (Busy) busy_cycles++;
      if ((k % BD) == BD / 2 && k / BD >= 1 && k / BD <= DW)
        rx_byte[k / BD - 1] = TxOut;
      if (scramble) begin
        PData      = DW'($urandom);
        ParityEn   = 1'($urandom_range(0, 1));
        ParityType = 1'($urandom_range(0, 1));
        DataValid  = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
    end
    check_val("rx_byte", 32'(rx_byte), 32'(d));
    check_val("idle_busy", 32'(Busy), 32'd0);
    check_val("idle_tx", 32'(TxOut), 32'd1);
    $display("[TB] frame data=%02h par_en=%0d par_odd=%0d busy_cycles=%0d (expect %0d)",
             d, pen, pt, busy_cycles, exp_n * BD);
  endtask

  // Called at a falling edge while the transmitter is idle.
  task automatic send(input logic [DW-1:0] d, input bit pen, input bit pt);
    PData      = d;
    ParityEn   = pen;
    ParityType = pt;
    DataValid  = 1'b1;
    @(negedge CLK);
    DataValid  = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    bit            rpen, rpt;

    repeat (3) @(negedge CLK);
    check_val("reset_tx", 32'(TxOut), 32'd1);
    check_val("reset_busy", 32'(Busy), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check_val("post_reset_tx", 32'(TxOut), 32'd1);

    send(8'hA5, 1'b0, 1'b0);
    check_frame(8'hA5, 1'b0, 1'b0, 1'b0);

    send(8'h03, 1'b1, 1'b0);
    check_frame(8'h03, 1'b1, 1'b0, 1'b0);
    send(8'h03, 1'b1, 1'b1);
    check_frame(8'h03, 1'b1, 1'b1, 1'b0);

    // DataValid held high: exactly one idle cycle between the two frames.
    PData = 8'h55; ParityEn = 1'b0; ParityType = 1'b0; DataValid = 1'b1;
    @(negedge CLK);
    PData = 8'hAA;
    check_frame(8'h55, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    DataValid = 1'b0;
    check_frame(8'hAA, 1'b0, 1'b0, 1'b0);

    // Mid-frame input noise and DataValid pulses, then no extra frame.
    send(8'h96, 1'b1, 1'b0);
    check_frame(8'h96, 1'b1, 1'b0, 1'b1);
    DataValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check_val("no_extra_tx", 32'(TxOut), 32'd1);
      check_val("no_extra_busy", 32'(Busy), 32'd0);
    end

    // Asynchronous reset in the middle of the data bits.
    send(8'h3C, 1'b0, 1'b0);
    repeat (30) @(negedge CLK);
    check_val("pre_abort_busy", 32'(Busy), 32'd1);
    RST = 1'b0;
    #1;
    check_val("abort_tx", 32'(TxOut), 32'd1);
    check_val("abort_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    check_val("abort_hold_tx", 32'(TxOut), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_val("recover_tx", 32'(TxOut), 32'd1);
    send(8'hC3, 1'b1, 1'b1);
    check_frame(8'hC3, 1'b1, 1'b1, 1'b0);

    for (int f = 0; f < 200; f++) begin
      rd   = DW'($urandom);
      rpen = 1'($urandom_range(0, 1));
      rpt  = 1'($urandom_range(0, 1));
      send(rd, rpen, rpt);
      check_frame(rd, rpen, rpt, 1'($urandom_range(0, 1)));
      DataValid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
